// File: rtl/register_file.sv
// 32 x 32-bit register file with two combinational read ports, write-through
// bypass, and an optional post-reset clear sweep that holds off writes.
module register_file #(
  parameter logic CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [4:0]  write_address,
  input  logic [31:0] write_data,
  input  logic        read_enable_1,
  input  logic [4:0]  read_address_1,
  input  logic        read_enable_2,
  input  logic [4:0]  read_address_2,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic        ready
);

  localparam int DATA_W = 32;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  state_t              state_next;
  logic [4:0]          sweep_count;
  logic [DATA_W-1:0]   regs [0:31];
  logic                sweep_active;
  logic                run_active;
  logic                write_commit;

  always_ff @(posedge clock) begin
    if (reset) state <= CLEAR_ON_RESET ? CLEAR : RUN;
    else       state <= state_next;
  end

  // RUN is absorbing; only reset leads back to CLEAR.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (sweep_count == 5'd31) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    sweep_active = (state == CLEAR) && !reset;
    run_active   = (state == RUN) && !reset;
    ready        = run_active;
    write_commit = run_active && write_enable && (write_address != 5'd0);
  end

  always_ff @(posedge clock) begin
    if (reset)             sweep_count <= 5'd0;
    else if (sweep_active) sweep_count <= sweep_count + 5'd1;
  end

  always_ff @(posedge clock) begin
    if (reset && !CLEAR_ON_RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (sweep_active) begin
      regs[sweep_count] <= '0;
    end else if (write_commit) begin
      regs[write_address] <= write_data;
    end
  end

  // A same-cycle write to the addressed register is forwarded ahead of storage.
  function automatic logic [DATA_W-1:0] read_port(input logic              en,
                                                  input logic [4:0]        addr,
                                                  input logic [DATA_W-1:0] stored);
    if (!run_active || !en || addr == 5'd0) return '0;
    if (write_commit && write_address == addr) return write_data;
    return stored;
  endfunction

  assign read_data_1 = read_port(read_enable_1, read_address_1, regs[read_address_1]);
  assign read_data_2 = read_port(read_enable_2, read_address_2, regs[read_address_2]);

endmodule
